// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM encoding
// and the rotating priority scan.
package rr_arbiter4_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_e;

    // Scan last_id+1 .. last_id+4 (mod 4); the first active request wins.
    // The previous owner is therefore always checked last.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [ID_W-1:0]  last_id
    );
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = last_id + ID_W'(off);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter4_decode_2to4.sv
// Index-to-one-hot decoder with enable; drives the per-requester grant lines.
module decode_2to4
    import rr_arbiter4_pkg::*;
(
    input  logic              en,
    input  logic [ID_W-1:0]   idx,
    output logic [N_REQ-1:0]  onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a bounded hold time and a
// one-cycle dead gap between consecutive grants.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              gnt_valid,
    output logic              timeout
);

    arb_state_e        state_q,     state_d;
    logic [ID_W-1:0]   gnt_id_q,    gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q,   timeout_d;
    logic [CNT_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [ID_W-1:0]   last_id_q,   last_id_d;

    logic              any_req;
    logic [ID_W-1:0]   winner;
    logic              owner_req;
    logic              hold_expired;

    assign any_req      = |req;
    assign winner       = rr_pick(req, last_id_q);
    assign owner_req    = req[gnt_id_q];
    assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                hold_cnt_d  = '0;
                gnt_valid_d = 1'b0;
                if (any_req) begin
                    state_d     = ST_GRANT;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                // Release is checked first so a drop on the last allowed
                // cycle is a normal release, not a revoke.
                if (!owner_req) begin
                    state_d     = ST_GAP;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    last_id_d   = gnt_id_q;
                end else if (hold_expired) begin
                    state_d     = ST_GAP;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    hold_cnt_d  = '0;
                    last_id_d   = gnt_id_q;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    decode_2to4 u_decode (
        .en     (gnt_valid_q),
        .idx    (gnt_id_q),
        .onehot (gnt)
    );

    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=4; expected values are hand-derived.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks;
    int errors;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks grant vector, valid and timeout together.
    task automatic chk_out(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(|exp_gnt));
        chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
        $display("step %s req=%b gnt=%b id=%0d valid=%b timeout=%b",
                 tag, req, gnt, gnt_id, gnt_valid, timeout);
    endtask

    initial begin
        logic [3:0] exp_g;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 4'b1111;

        // Reset held for 3 cycles with every request active.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("reset%0d", i), 4'b0000, 1'b0);
        end
        rst = 1'b0;

        // Starvation bound: owners 0,1,2,3,0 for exactly 4 cycles each.
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int k = 0; k < 4; k++) begin
                step();
                chk_out($sformatf("starve_g%0d_c%0d", g, k), exp_g, 1'b0);
                chk($sformatf("starve_g%0d_c%0d.id", g, k), 32'(gnt_id), 32'(g % 4));
                // Release on the final allowed cycle of the last grant.
                if (g == 4 && k == 3) req = 4'b0000;
            end
            if (g < 4) begin
                step();
                chk_out($sformatf("starve_gap%0d", g), 4'b0000, 1'b1);
            end
        end

        // Boundary: release at hold_cnt==MAX_HOLD-1 gives no timeout.
        step();
        chk_out("boundary_release", 4'b0000, 1'b0);
        step();
        chk_out("boundary_idle", 4'b0000, 1'b0);

        // Single requester 2; last owner was 0.
        req = 4'b0100;
        step();
        chk_out("single_grant", 4'b0100, 1'b0);
        chk("single_grant.id", 32'(gnt_id), 32'd2);
        step();
        chk_out("single_hold1", 4'b0100, 1'b0);
        step();
        chk_out("single_hold2", 4'b0100, 1'b0);
        req = 4'b0000;
        step();
        chk_out("single_release", 4'b0000, 1'b0);
        step();
        chk_out("single_idle", 4'b0000, 1'b0);

        // Rotation: last owner 2 -> requester 1 wins; then 0 and 1 both request.
        req = 4'b0010;
        step();
        chk_out("rot_grant1", 4'b0010, 1'b0);
        chk("rot_grant1.id", 32'(gnt_id), 32'd1);
        req = 4'b0011;
        for (int k = 1; k < 4; k++) begin
            step();
            chk_out($sformatf("rot_hold%0d", k), 4'b0010, 1'b0);
        end
        step();
        chk_out("rot_revoke", 4'b0000, 1'b1);
        step();
        chk_out("rot_grant0", 4'b0001, 1'b0);
        chk("rot_grant0.id", 32'(gnt_id), 32'd0);

        // Owner 0 releases while requester 3 waits: one dead cycle then grant 3.
        req = 4'b1000;
        step();
        chk_out("handoff_gap", 4'b0000, 1'b0);
        step();
        chk_out("handoff_grant3", 4'b1000, 1'b0);
        chk("handoff_grant3.id", 32'(gnt_id), 32'd3);

        // Reset mid-grant: grant drops, no timeout, priority restarts at 0.
        rst = 1'b1;
        step();
        chk_out("midrst", 4'b0000, 1'b0);
        chk("midrst.id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk_out("postrst_grant", 4'b0001, 1'b0);
        chk("postrst_grant.id", 32'(gnt_id), 32'd0);
        req = 4'b0000;
        step();
        chk_out("final_release", 4'b0000, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
